// File: rtl/sprite_ram_arbiter.sv
// sprite_ram_arbiter
// Shares one sprite frame RAM between three read clients and one write client.
// Port 0 (VGA sprite draw) has fixed top priority. Ports 1 and 2 alternate
// round-robin when they contend. Read data comes back tagged one cycle after
// grant. The block also flags starvation and out-of-range accesses.
// Optional feature macro: SPRITE_ARB_RDW_BYPASS_EN. When it is defined, a
// read and a write to the same in-range address in the same cycle return the
// new write data instead of the RAM's old data.
module sprite_ram_arbiter #(
   parameter int unsigned ADDR_W       = 19,
   parameter int unsigned DATA_W       = 5,
   parameter int unsigned DEPTH        = 400,
   parameter int unsigned STARVE_LIMIT = 64
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [2:0]        rreq,
   input  logic [ADDR_W-1:0] raddr0,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [2:0]        rgnt,
   output logic [2:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   input  logic              wreq,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic              wgnt,
   output logic [ADDR_W-1:0] ram_read_address,
   output logic [ADDR_W-1:0] ram_write_address,
   output logic [DATA_W-1:0] ram_data_In,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_data_Out,
   output logic [2:1]        starve,
   output logic              range_err
);

   localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
   localparam logic [7:0]        LIMIT_W   = 8'(STARVE_LIMIT);
   localparam logic [7:0]        WAIT_MAX  = 8'd255;

   // Address lies inside the populated part of the sprite RAM
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a < DEPTH_A);
   endfunction

   // Saturating 8-bit increment for the wait counters
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == WAIT_MAX) ? WAIT_MAX : (v + 8'd1);
   endfunction

   logic              r_rr_ptr;     // 0: port 1 wins next contention, 1: port 2
   logic [2:0]        r_rvalid;
   logic              r_rd_zero;    // returned read was out of range
   logic              r_range_err;
   logic [7:0]        r_wait1;
   logic [7:0]        r_wait2;
   logic [2:1]        r_starve;

   logic [2:0]        w_gnt;
   logic [ADDR_W-1:0] w_sel_addr;
   logic              w_contend;
   logic              w_rd_any;
   logic              w_rd_ok;
   logic              w_rd_oor;
   logic              w_wr_ok;
   logic              w_wr_oor;
   logic [7:0]        w_wait1_nxt;
   logic [7:0]        w_wait2_nxt;

   // Fixed-priority plus round-robin grant and the winner's address
   always_comb begin
      w_gnt      = 3'b000;
      w_sel_addr = '0;
      if (rreq[0]) begin
         w_gnt      = 3'b001;
         w_sel_addr = raddr0;
      end else if (rreq[1] && rreq[2]) begin
         if (r_rr_ptr == 1'b0) begin
            w_gnt      = 3'b010;
            w_sel_addr = raddr1;
         end else begin
            w_gnt      = 3'b100;
            w_sel_addr = raddr2;
         end
      end else if (rreq[1]) begin
         w_gnt      = 3'b010;
         w_sel_addr = raddr1;
      end else if (rreq[2]) begin
         w_gnt      = 3'b100;
         w_sel_addr = raddr2;
      end else begin
         w_gnt      = 3'b000;
         w_sel_addr = '0;
      end
   end

   assign w_contend = ~rreq[0] & rreq[1] & rreq[2];
   assign w_rd_any  = |w_gnt;
   assign w_rd_ok   = in_range(w_sel_addr);
   assign w_rd_oor  = w_rd_any & ~w_rd_ok;
   assign w_wr_ok   = wreq & in_range(waddr);
   assign w_wr_oor  = wreq & ~in_range(waddr);

   assign rgnt              = w_gnt;
   assign wgnt              = wreq;
   assign ram_read_address  = (w_rd_any && w_rd_ok) ? w_sel_addr : '0;
   assign ram_we            = w_wr_ok;
   assign ram_write_address = w_wr_ok ? waddr : '0;
   assign ram_data_In       = w_wr_ok ? wdata : '0;

   // Next wait count: grow while requesting and denied, clear otherwise
   always_comb begin
      w_wait1_nxt = 8'd0;
      w_wait2_nxt = 8'd0;
      if (rreq[1] && !w_gnt[1]) begin
         w_wait1_nxt = sat_inc(r_wait1);
      end else begin
         w_wait1_nxt = 8'd0;
      end
      if (rreq[2] && !w_gnt[2]) begin
         w_wait2_nxt = sat_inc(r_wait2);
      end else begin
         w_wait2_nxt = 8'd0;
      end
   end

   // Round-robin pointer flips only after an unpreempted 1-vs-2 contention
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_rr_ptr <= 1'b0;
      end else if (w_contend) begin
         r_rr_ptr <= ~r_rr_ptr;
      end else begin
         r_rr_ptr <= r_rr_ptr;
      end
   end

   // Read return tagging and range error pulse, one cycle after the grant
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_rvalid    <= 3'b000;
         r_rd_zero   <= 1'b0;
         r_range_err <= 1'b0;
      end else begin
         r_rvalid    <= w_gnt;
         r_rd_zero   <= w_rd_oor;
         r_range_err <= w_rd_oor | w_wr_oor;
      end
   end

   // Wait counters and the starve flags derived from their next value
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_wait1  <= 8'd0;
         r_wait2  <= 8'd0;
         r_starve <= 2'b00;
      end else begin
         r_wait1     <= w_wait1_nxt;
         r_wait2     <= w_wait2_nxt;
         r_starve[1] <= (w_wait1_nxt >= LIMIT_W);
         r_starve[2] <= (w_wait2_nxt >= LIMIT_W);
      end
   end

`ifdef SPRITE_ARB_RDW_BYPASS_EN
   logic              r_byp;
   logic [DATA_W-1:0] r_byp_data;

   // Capture same-cycle read/write address hits so the read returns new data
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_byp      <= 1'b0;
         r_byp_data <= '0;
      end else begin
         r_byp      <= w_rd_any & w_rd_ok & w_wr_ok & (w_sel_addr == waddr);
         r_byp_data <= wdata;
      end
   end

   // Return data mux: zero when idle or out of range, bypass on a hit
   always_comb begin
      rdata = '0;
      if (r_rvalid == 3'b000) begin
         rdata = '0;
      end else if (r_rd_zero) begin
         rdata = '0;
      end else if (r_byp) begin
         rdata = r_byp_data;
      end else begin
         rdata = ram_data_Out;
      end
   end
`else
   // Return data mux: zero when idle or out of range, RAM output otherwise
   always_comb begin
      rdata = '0;
      if (r_rvalid == 3'b000) begin
         rdata = '0;
      end else if (r_rd_zero) begin
         rdata = '0;
      end else begin
         rdata = ram_data_Out;
      end
   end
`endif

   assign rvalid    = r_rvalid;
   assign range_err = r_range_err;
   assign starve    = r_starve;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Testbench for sprite_ram_arbiter. It has a behavioural RAM, a reference
// model driven by stimulus and a scoreboard monitor for the registered returns.
module tb_sprite_ram_arbiter;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 5;
   localparam int DEPTH  = 400;
   localparam int LIMIT  = 64;
`ifdef SPRITE_ARB_RDW_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              Clk = 1'b0;
   logic              Reset_n = 1'b0;
   logic [2:0]        rreq = 3'b000;
   logic [ADDR_W-1:0] raddr0 = '0, raddr1 = '0, raddr2 = '0;
   logic [2:0]        rgnt, rvalid;
   logic [DATA_W-1:0] rdata;
   logic              wreq = 1'b0;
   logic [ADDR_W-1:0] waddr = '0;
   logic [DATA_W-1:0] wdata = '0;
   logic              wgnt;
   logic [ADDR_W-1:0] ram_read_address, ram_write_address;
   logic [DATA_W-1:0] ram_data_In;
   logic              ram_we;
   logic [DATA_W-1:0] ram_data_Out;
   logic [2:1]        starve;
   logic              range_err;

   sprite_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .rreq(rreq),
      .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
      .rgnt(rgnt), .rvalid(rvalid), .rdata(rdata),
      .wreq(wreq), .waddr(waddr), .wdata(wdata), .wgnt(wgnt),
      .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
      .ram_data_In(ram_data_In), .ram_we(ram_we), .ram_data_Out(ram_data_Out),
      .starve(starve), .range_err(range_err)
   );

   always #5 Clk = ~Clk;

   // Behavioural frame RAM: registered read returning old data on a collision
   logic [DATA_W-1:0] ram_mem [0:DEPTH-1];
   always @(posedge Clk) begin
      if (int'(ram_read_address) < DEPTH) ram_data_Out <= ram_mem[int'(ram_read_address)];
      else                                ram_data_Out <= 5'h1F;
      if (ram_we && int'(ram_write_address) < DEPTH) ram_mem[int'(ram_write_address)] <= ram_data_In;
   end

   typedef struct packed {
      logic [2:0] rv;
      logic [4:0] rd;
      logic       re;
      logic [1:0] st;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   int gold [0:DEPTH-1];
   int pref  = 1;
   int wait1 = 0;
   int wait2 = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One bus cycle: drive, check combinational outputs, queue the expected return
   task automatic cycle(input logic [2:0] rq, input int a0, input int a1, input int a2,
                        input logic wq, input int wa, input int wd);
      int g, ra;
      bit rd_oor, wr_ok;
      exp_t e;
      @(negedge Clk);
      rreq = rq; raddr0 = ADDR_W'(a0); raddr1 = ADDR_W'(a1); raddr2 = ADDR_W'(a2);
      wreq = wq; waddr = ADDR_W'(wa); wdata = DATA_W'(wd);
      #1;
      if (rq[0])               g = 0;
      else if (rq[1] && rq[2]) g = pref;
      else if (rq[1])          g = 1;
      else if (rq[2])          g = 2;
      else                     g = -1;
      if (!rq[0] && rq[1] && rq[2]) pref = (g == 1) ? 2 : 1;
      ra     = (g == 0) ? a0 : (g == 1) ? a1 : (g == 2) ? a2 : 0;
      rd_oor = (g >= 0) && (ra >= DEPTH);
      wr_ok  = wq && (wa < DEPTH);
      chk("rgnt", 32'(rgnt), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("ram_read_address", 32'(ram_read_address), (g >= 0 && !rd_oor) ? 32'(ra) : 32'd0);
      chk("ram_we", 32'(ram_we), 32'(wr_ok));
      chk("wgnt", 32'(wgnt), 32'(wq));
      if (wr_ok) begin
         chk("ram_write_address", 32'(ram_write_address), 32'(wa));
         chk("ram_data_In", 32'(ram_data_In), 32'(wd));
      end
      e.rv = (g >= 0) ? 3'(1 << g) : 3'b000;
      if (g < 0 || rd_oor)                    e.rd = 5'd0;
      else if (BYP && wr_ok && (wa == ra))    e.rd = 5'(wd);
      else                                    e.rd = 5'(gold[ra]);
      e.re  = rd_oor || (wq && wa >= DEPTH);
      wait1 = (rq[1] && g != 1) ? ((wait1 < 255) ? wait1 + 1 : 255) : 0;
      wait2 = (rq[2] && g != 2) ? ((wait2 < 255) ? wait2 + 1 : 255) : 0;
      e.st  = {wait2 >= LIMIT, wait1 >= LIMIT};
      sbq.push_back(e);
      if (wr_ok) gold[wa] = wd;
   endtask

   // Assert reset between edges and check that in-flight returns vanish at once
   task automatic do_reset();
      @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("reset rvalid", 32'(rvalid), 32'd0);
      chk("reset rdata", 32'(rdata), 32'd0);
      chk("reset range_err", 32'(range_err), 32'd0);
      chk("reset starve", 32'(starve), 32'd0);
      sbq.delete();
      pref = 1; wait1 = 0; wait2 = 0;
      repeat (2) @(negedge Clk);
      rreq = 3'b000; wreq = 1'b0;
      Reset_n = 1'b1;
   endtask

   // Scoreboard monitor: one expected entry per driven cycle, compared after the edge
   always @(posedge Clk) begin
      #1;
      if (sbq.size() > 0) begin
         mon_e = sbq.pop_front();
         chk("rvalid", 32'(rvalid), 32'(mon_e.rv));
         if (mon_e.rv != 3'b000) chk("rdata", 32'(rdata), 32'(mon_e.rd));
         chk("range_err", 32'(range_err), 32'(mon_e.re));
         chk("starve", 32'(starve), 32'(mon_e.st));
      end else if (Reset_n && (rvalid != 3'b000 || range_err)) begin
         chk("unexpected return", {28'd0, range_err, rvalid}, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int rq, a0, a1, a2, wa;
      #3;
      chk("por rvalid", 32'(rvalid), 32'd0);
      chk("por rdata", 32'(rdata), 32'd0);
      chk("por starve", 32'(starve), 32'd0);
      chk("por range_err", 32'(range_err), 32'd0);
      chk("por rgnt", 32'(rgnt), 32'd0);
      chk("por ram_we", 32'(ram_we), 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;

      // Preload every RAM entry through the write port
      for (int a = 0; a < DEPTH; a++) cycle(3'b000, 0, 0, 0, 1'b1, a, int'($urandom_range(0, 31)));

      // Priority: port 0 wins every cycle
      repeat (4) cycle(3'b111, 5, 1, 2, 1'b0, 0, 0);

      // Reset in the middle of a port 1 read
      cycle(3'b010, 0, 10, 0, 1'b0, 0, 0);
      do_reset();

      // Round-robin from the reset pointer: 010, 100, 010, 100
      repeat (4) cycle(3'b110, 0, 11, 12, 1'b0, 0, 0);

      // Starvation of port 1 behind a streaming port 0, then release
      repeat (70) cycle(3'b011, 3, 4, 0, 1'b0, 0, 0);
      cycle(3'b010, 0, 4, 0, 1'b0, 0, 0);
      cycle(3'b000, 0, 0, 0, 1'b0, 0, 0);

      // Out-of-range read, out-of-range write, then address 0 unchanged
      cycle(3'b010, 0, 400, 0, 1'b0, 0, 0);
      cycle(3'b000, 0, 0, 0, 1'b1, 512, 17);
      cycle(3'b010, 0, 0, 0, 1'b0, 0, 0);

      // Read-during-write to address 7
      cycle(3'b000, 0, 0, 0, 1'b1, 7, 3);
      cycle(3'b001, 7, 0, 0, 1'b1, 7, 9);
      cycle(3'b001, 7, 0, 0, 1'b0, 0, 0);

      // Randomised traffic with frequent address collisions
      for (int i = 0; i < 500; i++) begin
         rq = int'($urandom_range(0, 7));
         a0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(400, 600)) : int'($urandom_range(0, 15));
         a1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(400, 600)) : int'($urandom_range(0, 15));
         a2 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(400, 600)) : int'($urandom_range(0, 15));
         wa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(400, 600)) : int'($urandom_range(0, 15));
         cycle(3'(rq), a0, a1, a2, 1'($urandom_range(0, 1)), wa, int'($urandom_range(0, 31)));
      end

      repeat (3) cycle(3'b000, 0, 0, 0, 1'b0, 0, 0);
      @(posedge Clk);
      #3;
      chk("scoreboard drained", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sprite_ram_arbiter.md
# sprite_ram_arbiter

Shares one sprite frame RAM (19-bit address, 5-bit data port, 1-cycle registered read, independent write port) between three read clients and one write client. Port 0 is the VGA sprite-draw path and always wins. Ports 1 and 2 are secondary readers, such as collision lookup and scoreboard render, and share the remaining read slots round-robin. The block sits between the renderers/loader and the frame RAM instance, returns tagged read data one cycle after grant, and flags starvation and out-of-range accesses.

## Interface
- ADDR_W, 19, RAM address width
- DATA_W, 5, RAM data width
- DEPTH, 400, valid RAM entries (20x20 sprite); addresses >= DEPTH are out of range
- STARVE_LIMIT, 64, consecutive denied cycles before a port's starve flag sets
- Clk  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- rreq[2:0]  in  3  read request per port
- raddr0/raddr1/raddr2  in  ADDR_W each  read address per port
- rgnt[2:0]  out  3  read grant, combinational, one-hot or zero
- rvalid[2:0]  out  3  read data valid, one-hot or zero, registered
- rdata  out  DATA_W  read data, shared bus qualified by rvalid
- wreq  in  1  write request
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- wgnt  out  1  write accepted
- ram_read_address, ram_write_address  out  ADDR_W  to RAM
- ram_data_In  out  DATA_W  to RAM
- ram_we  out  1  to RAM
- ram_data_Out  in  DATA_W  from RAM, valid 1 cycle after address
- starve[2:1]  out  2  wait counter of port 1/2 reached STARVE_LIMIT
- range_err  out  1  1-cycle pulse on an out-of-range access

## Operation
- Read arbitration is evaluated each cycle from rreq:
  - rreq[0] set: rgnt = 001.
  - Otherwise, if only one of ports 1 and 2 requests, that port wins.
  - If both request, the port named by rr_ptr wins, and rr_ptr then flips to the other port.
  - rr_ptr changes only when ports 1 and 2 contend and neither is preempted by port 0.
- ram_read_address is the winner's raddr, or 0 when nothing is granted.
- In-range granted read: rvalid of the granted port is set next cycle and rdata = ram_data_Out.
- Out-of-range granted read: RAM address is forced to 0, rdata = 0 next cycle, rvalid still pulses, and range_err pulses with it.
- Writes: wgnt = wreq every cycle. The write port is independent of the read arbitration.
  - In range: ram_we = 1 with waddr/wdata passed through.
  - Out of range: ram_we = 0 and range_err pulses next cycle.
- Wait counters (ports 1, 2):
  - 8-bit, saturating at 255.
  - Increment when rreq is high and rgnt is low; clear on grant or when rreq drops.
  - starve[i] = counter >= STARVE_LIMIT, registered.
- Reset values: rvalid = 0, rdata = 0, rr_ptr = port 1, counters = 0, starve = 0, range_err = 0. rgnt, ram_we and ram_read_address follow their combinational rules, and are 0 when no request is present.
- Reset asserted mid-operation: the in-flight rvalid clears immediately and its data is discarded. After release, arbitration restarts from the reset state.

## Timing
- Request sampled and grant driven in cycle N. rvalid/rdata appear in N+1 (latency 1). Throughput is one read per cycle.
- Request handshake: a requester holds rreq and raddr until it sees rgnt high in the same cycle. A dropped request loses its place with no penalty.
- Port 1 alone while port 0 streams continuously: port 1 is never granted; starve[1] rises STARVE_LIMIT+1 cycles after its request began.
- Read and write in the same cycle to the same address: governed by the Configuration section.

## Configuration
- SPRITE_ARB_RDW_BYPASS_EN
  - Defined: when a granted in-range read address equals an in-range written address in the same cycle, the next-cycle rdata is the registered wdata (new data), not ram_data_Out.
  - Undefined: rdata is always ram_data_Out (old data, raw RAM read-during-write behaviour). No compare or bypass registers are built.

## Test plan
- Reset: Reset_n low mid-read with rvalid = 010 -> rvalid = 000 and rdata = 0 immediately; first grant after release with rreq = 110 goes to port 1.
- Priority: rreq = 111 for 4 cycles, raddr0 = 5 -> rgnt = 001 every cycle; rvalid = 001 each cycle from cycle 2 with rdata = mem[5].
- Round-robin: rreq = 110 for 4 cycles -> grants in order 010, 100, 010, 100; rvalid tracks one cycle later.
- Starvation: rreq[0] = 1 and rreq[1] = 1 held, STARVE_LIMIT = 64 -> starve[1] is 0 through cycle 64 and 1 from cycle 65; dropping rreq[0] grants port 1, and starve[1] clears the next cycle.
- Range: read raddr1 = 400 -> rvalid = 010, rdata = 0, range_err pulse. Write waddr = 512 -> ram_we = 0, range_err pulse; a subsequent read of address 0 is unchanged.
- Bypass: mem[7] = 3, write waddr = 7, wdata = 9 while port 0 reads 7 in the same cycle -> rdata = 9 with the macro defined, 3 without it; the next read of 7 returns 9 in both builds.
